// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encodings and the
// state width, also used by bench-side monitors.
package counter_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status and counter-side signals of the counter sequencer.
// master: system control logic plus the counter instance (drives cnt).
// slave:  the sequencer itself.
interface counter_ctrl_if #(
   parameter int WIDTH = 4
);

   logic             start;
   logic             stop;
   logic             periodic;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_en;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, periodic, limit, cnt,
      input  cnt_clr, cnt_en, busy, done
   );

   modport slave (
      input  start, stop, periodic, limit, cnt,
      output cnt_clr, cnt_en, busy, done
   );

endinterface

// File: rtl/counter_ctrl_prescaler.sv
// Free-running PRE_W-bit prescaler with synchronous zero. tick is high when
// the count is all ones, so the first tick after zero lands on cycle 2**PRE_W.
// Only instantiated when COUNTER_CTRL_PRESCALE_EN is defined.
module counter_ctrl_prescaler #(
   parameter int PRE_W = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic zero,
   output logic tick
);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   // Next prescaler value: hold at zero outside RUN, otherwise free-run.
   always_comb begin
      pre_d = pre_q + 1'b1;
      if (zero) begin
         pre_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick = &pre_q;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a WIDTH-bit up-counter: clears it, enables it up to the
// latched limit, pulses done, then idles (one-shot) or restarts (periodic).
// Optional prescaler on the count enable: COUNTER_CTRL_PRESCALE_EN.
//
// state | meaning
// IDLE  | waiting for start, counter untouched
// CLEAR | one-cycle synchronous clear of the counter
// RUN   | counting towards limit_q
// DONE  | done pulse, counter cleared for the next period
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int PRE_W = 2
) (
   input  logic           clk,
   input  logic           clr,
   counter_ctrl_if.slave  bus
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] limit_d;
   logic             mode_q;
   logic             mode_d;
   logic             tick;
   logic             at_limit;

   assign at_limit = (bus.cnt == limit_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
   counter_ctrl_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk  (clk),
      .clr  (clr),
      .zero (state_q != ST_RUN),
      .tick (tick)
   );
`else
   logic unused_pre_w;
   assign unused_pre_w = (PRE_W > 0);
   assign tick         = 1'b1;
`endif

   // State and latched request registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         limit_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         mode_q  <= mode_d;
      end
   end

   // Next state; limit and mode are captured only on an accepted start.
   always_comb begin
      state_d = state_q;
      limit_d = limit_q;
      mode_d  = mode_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = ST_CLEAR;
               limit_d = bus.limit;
               mode_d  = bus.periodic;
            end
         end
         ST_CLEAR: begin
            state_d = bus.stop ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (at_limit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.stop || !mode_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: Moore from state, except cnt_en which reacts to stop at once.
   // cnt_clr also follows clr directly so the counter sees a clear request
   // for the whole time the sequencer is held in reset.
   always_comb begin
      bus.busy    = (state_q != ST_IDLE);
      bus.done    = (state_q == ST_DONE);
      bus.cnt_clr = clr || (state_q == ST_CLEAR) || (state_q == ST_DONE);
      bus.cnt_en  = (state_q == ST_RUN) && !bus.stop && tick && !at_limit;
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural 4-bit counter.
module tb_counter_ctrl;

`ifdef COUNTER_CTRL_PRESCALE_EN
   localparam int PRE_W = 1;
`else
   localparam int PRE_W = 2;
`endif

   logic clk;
   logic clr;
   int   n_vec;
   int   n_err;

   counter_ctrl_if #(.WIDTH(4)) bus ();

   counter_ctrl #(
      .WIDTH (4),
      .PRE_W (PRE_W)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter instance model: synchronous clear, count enable.
   always_ff @(posedge clk) begin
      if (bus.cnt_clr) begin
         bus.cnt <= '0;
      end else if (bus.cnt_en) begin
         bus.cnt <= bus.cnt + 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 2 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // One-shot run; start is driven now, cycle k is k edges later.
   task automatic oneshot(input logic [3:0] lim);
      int en_cnt;
      en_cnt = 0;
      bus.start    = 1'b1;
      bus.limit    = lim;
      bus.periodic = 1'b0;
      cyc();
      bus.start    = 1'b0;
      bus.limit    = ~lim;
      bus.periodic = 1'b1;
      chk("clear_busy", bus.busy, 1);
      chk("clear_cnt_clr", bus.cnt_clr, 1);
      chk("clear_done", bus.done, 0);
      for (int k = 2; k <= lim + 3; k++) begin
         cyc();
         if (k <= lim + 2) begin
            chk("run_cnt", bus.cnt, k - 2);
            chk("run_en", bus.cnt_en, (k - 2) != lim);
            chk("run_done", bus.done, 0);
            chk("run_busy", bus.busy, 1);
            if (bus.cnt_en) en_cnt++;
         end else begin
            chk("done_pulse", bus.done, 1);
            chk("done_cnt", bus.cnt, lim);
            chk("done_cnt_clr", bus.cnt_clr, 1);
         end
      end
      cyc();
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_cnt", bus.cnt, 0);
      chk("en_cycles", en_cnt, lim);
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      clr          = 1'b1;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.periodic = 1'b0;
      bus.limit    = 4'd0;
      repeat (3) cyc();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cnt_en", bus.cnt_en, 0);
      chk("rst_cnt_clr", bus.cnt_clr, 1);
      chk("rst_cnt", bus.cnt, 0);
      clr = 1'b0;
      cyc();
      chk("post_rst_cnt_clr", bus.cnt_clr, 0);

`ifdef COUNTER_CTRL_PRESCALE_EN
      // Prescaled one-shot, limit 3, PRE_W 1.
      bus.start = 1'b1;
      bus.limit = 4'd3;
      cyc();
      bus.start = 1'b0;
      chk("pre_clear", bus.cnt_clr, 1);
      for (int k = 2; k <= 8; k++) begin
         cyc();
         chk("pre_cnt", bus.cnt, (k - 2) / 2);
         chk("pre_en", bus.cnt_en, ((k - 1) % 2 == 0) && ((k - 2) / 2 != 3));
         chk("pre_nodone", bus.done, 0);
      end
      cyc();
      chk("pre_done", bus.done, 1);
      chk("pre_done_cnt", bus.cnt, 3);
      cyc();
      chk("pre_idle", bus.busy, 0);
`else
      // One-shot, limit 5.
      oneshot(4'd5);

      // Periodic, limit 3: done every 5 cycles, busy throughout.
      bus.start    = 1'b1;
      bus.limit    = 4'd3;
      bus.periodic = 1'b1;
      cyc();
      bus.start    = 1'b0;
      bus.periodic = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) cyc();
         chk("per_busy", bus.busy, 1);
         chk("per_done", bus.done, (k >= 6) && ((k - 6) % 5 == 0));
         if (k >= 2) begin
            chk("per_cnt", bus.cnt, ((k - 2) % 5 == 4) ? 3 : (k - 2) % 5);
         end
      end
      cyc();
      bus.stop = 1'b1;
      #1;
      chk("per_stop_en", bus.cnt_en, 0);
      chk("per_stop_busy", bus.busy, 1);
      cyc();
      chk("per_stopped_busy", bus.busy, 0);
      chk("per_stopped_done", bus.done, 0);
      bus.stop = 1'b0;
      cyc();

      // Boundary limits.
      oneshot(4'd0);
      oneshot(4'd15);

      // Stop mid-RUN at cnt 2; start while busy ignored.
      bus.start = 1'b1;
      bus.limit = 4'd9;
      cyc();
      bus.start = 1'b0;
      cyc();
      cyc();
      chk("stp_cnt1", bus.cnt, 1);
      bus.start = 1'b1;
      bus.limit = 4'd1;
      cyc();
      bus.start = 1'b0;
      chk("stp_restart_ignored", bus.done, 0);
      chk("stp_cnt2", bus.cnt, 2);
      bus.stop = 1'b1;
      #1;
      chk("stp_en_forced", bus.cnt_en, 0);
      cyc();
      chk("stp_busy", bus.busy, 0);
      chk("stp_done", bus.done, 0);
      chk("stp_hold", bus.cnt, 2);
      bus.start = 1'b1;
      cyc();
      chk("stp_start_and_stop", bus.busy, 0);
      chk("stp_hold2", bus.cnt, 2);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      cyc();

      // Asynchronous clr mid-RUN.
      bus.start = 1'b1;
      bus.limit = 4'd8;
      cyc();
      bus.start = 1'b0;
      repeat (3) cyc();
      chk("clr_pre_busy", bus.busy, 1);
      chk("clr_pre_en", bus.cnt_en, 1);
      #1;
      clr = 1'b1;
      #1;
      chk("clr_busy", bus.busy, 0);
      chk("clr_done", bus.done, 0);
      chk("clr_en", bus.cnt_en, 0);
      chk("clr_cnt_clr", bus.cnt_clr, 1);
      cyc();
      cyc();
      clr = 1'b0;
      cyc();
      oneshot(4'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
